// File: rtl/tb_runctl.sv
// Bench run controller: holds the DUT in reset, waits a settle window, then
// runs a bounded cycle count and latches pass/fail/timeout as sticky status.
module tb_runctl #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 100000,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             done_req,
    input  logic             done_pass,
    output logic             dut_rst,
    output logic             run,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             finished,
    output logic             passed,
    output logic             timed_out
);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int SC_W   = (SC_MAX < 1) ? 1 : $clog2(SC_MAX + 1);

    state_t           cur, cur_nxt;
    logic [SC_W-1:0]  sub_cnt, sub_nxt;
    logic [CNT_W-1:0] cycle_nxt;
    logic             dut_rst_nxt, run_nxt, finished_nxt, passed_nxt, timed_out_nxt;
    logic             go_hold;

    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= HOLD;
            sub_cnt   <= '0;
            dut_rst   <= 1'b1;
            run       <= 1'b0;
            cycle_cnt <= '0;
            finished  <= 1'b0;
            passed    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            cur       <= cur_nxt;
            sub_cnt   <= sub_nxt;
            dut_rst   <= dut_rst_nxt;
            run       <= run_nxt;
            cycle_cnt <= cycle_nxt;
            finished  <= finished_nxt;
            passed    <= passed_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    // restart is honoured everywhere except HOLD and overrides the per-state decisions
    assign go_hold = restart && (cur != HOLD);

    always_comb begin
        cur_nxt       = cur;
        sub_nxt       = sub_cnt;
        dut_rst_nxt   = dut_rst;
        run_nxt       = run;
        cycle_nxt     = cycle_cnt;
        finished_nxt  = finished;
        passed_nxt    = passed;
        timed_out_nxt = timed_out;

        case (cur)
            HOLD: begin
                dut_rst_nxt = 1'b1;
                run_nxt     = 1'b0;
                if (sub_cnt == SC_W'(RST_CYCLES - 1)) begin
                    sub_nxt     = '0;
                    dut_rst_nxt = 1'b0;
                    if (SETTLE_CYCLES > 0) begin
                        cur_nxt = SETTLE;
                    end else begin
                        cur_nxt = RUN;
                        run_nxt = 1'b1;
                    end
                end else begin
                    sub_nxt = sub_cnt + 1'b1;
                end
            end
            SETTLE: begin
                dut_rst_nxt = 1'b0;
                run_nxt     = 1'b0;
                if (sub_cnt == SC_W'(SETTLE_CYCLES - 1)) begin
                    sub_nxt = '0;
                    cur_nxt = RUN;
                    run_nxt = 1'b1;
                end else begin
                    sub_nxt = sub_cnt + 1'b1;
                end
            end
            RUN: begin
                cycle_nxt = cycle_cnt + 1'b1;
                if (done_req) begin
                    cur_nxt       = DONE;
                    run_nxt       = 1'b0;
                    finished_nxt  = 1'b1;
                    passed_nxt    = done_pass;
                    timed_out_nxt = 1'b0;
                end else if (cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    cur_nxt       = DONE;
                    run_nxt       = 1'b0;
                    finished_nxt  = 1'b1;
                    passed_nxt    = 1'b0;
                    timed_out_nxt = 1'b1;
                end
            end
            DONE: begin
                run_nxt     = 1'b0;
                dut_rst_nxt = 1'b0;
            end
            default: cur_nxt = HOLD;
        endcase

        if (go_hold) begin
            cur_nxt       = HOLD;
            sub_nxt       = '0;
            dut_rst_nxt   = 1'b1;
            run_nxt       = 1'b0;
            cycle_nxt     = '0;
            finished_nxt  = 1'b0;
            passed_nxt    = 1'b0;
            timed_out_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_tb_runctl.sv
// Bench for tb_runctl: directed scenarios plus random restart/done/rst traffic,
// checked against a phase model built from edge counts since the last HOLD entry.
module tb_tb_runctl;

    localparam int R  = 4;
    localparam int S  = 2;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        done_req = 1'b0;
    logic        done_pass = 1'b0;
    logic        dut_rst, run, finished, passed, timed_out;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    logic        z_restart = 1'b0;
    logic        z_done_req = 1'b0;
    logic        z_done_pass = 1'b0;
    logic        z_dut_rst, z_run, z_finished, z_passed, z_timed_out;
    logic [1:0]  z_state;
    logic [31:0] z_cycle_cnt;

    int total = 0;
    int bad   = 0;

    // model: edges since HOLD entry decide the phase; runs counts RUN edges
    int m_since, m_runs;
    bit m_fin, m_pas, m_tmo;

    tb_runctl #(.RST_CYCLES(R), .SETTLE_CYCLES(S), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .restart(restart), .done_req(done_req), .done_pass(done_pass),
        .dut_rst(dut_rst), .run(run), .state(state), .cycle_cnt(cycle_cnt),
        .finished(finished), .passed(passed), .timed_out(timed_out)
    );

    tb_runctl #(.RST_CYCLES(R), .SETTLE_CYCLES(0), .TIMEOUT(20), .CNT_W(32)) dut_z (
        .clk(clk), .rst(rst), .restart(z_restart), .done_req(z_done_req), .done_pass(z_done_pass),
        .dut_rst(z_dut_rst), .run(z_run), .state(z_state), .cycle_cnt(z_cycle_cnt),
        .finished(z_finished), .passed(z_passed), .timed_out(z_timed_out)
    );

    always #5 clk = ~clk;

    function automatic int m_phase();
        if (m_since < R) return 0;
        if (m_since < R + S) return 1;
        return m_fin ? 3 : 2;
    endfunction

    task automatic m_reset();
        m_since = 0;
        m_runs  = 0;
        m_fin   = 1'b0;
        m_pas   = 1'b0;
        m_tmo   = 1'b0;
    endtask

    task automatic m_edge();
        case (m_phase())
            0: m_since++;
            1: if (restart) m_reset(); else m_since++;
            2: begin
                if (restart) m_reset();
                else begin
                    m_runs++;
                    if (done_req) begin
                        m_fin = 1'b1;
                        m_pas = done_pass;
                    end else if (m_runs == TO) begin
                        m_fin = 1'b1;
                        m_tmo = 1'b1;
                    end
                end
            end
            default: if (restart) m_reset();
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("m_state",     32'(state),     32'(m_phase()));
        check("m_dut_rst",   32'(dut_rst),   32'(m_phase() == 0));
        check("m_run",       32'(run),       32'(m_phase() == 2));
        check("m_cycle_cnt", cycle_cnt,      32'(m_runs));
        check("m_finished",  32'(finished),  32'(m_fin));
        check("m_passed",    32'(passed),    32'(m_pas));
        check("m_timed_out", 32'(timed_out), 32'(m_tmo));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) m_reset(); else m_edge();
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_reset();

        // reset held for 3 edges
        steps(3);
        check("rst_state",   32'(state),     32'd0);
        check("rst_dut_rst", 32'(dut_rst),   32'd1);
        check("rst_cnt",     cycle_cnt,      32'd0);
        check("rst_flags",   32'({finished, passed, timed_out}), 32'd0);
        rst = 1'b0;

        // power-up sequencing, both builds
        for (int e = 1; e <= 6; e++) begin
            step();
            check("s1_dut_rst", 32'(dut_rst), 32'(e < 4));
            check("s1_run",     32'(run),     32'(e >= 6));
            check("s1_state",   32'(state),   (e < 4) ? 32'd0 : (e < 6) ? 32'd1 : 32'd2);
            check("z_dut_rst",  32'(z_dut_rst), 32'(e < 4));
            check("z_run",      32'(z_run),     32'(e >= 4));
        end

        // completion on the 10th RUN edge
        steps(9);
        done_req = 1'b1; done_pass = 1'b1;
        step();
        done_req = 1'b0;
        check("s2_state",  32'(state),     32'd3);
        check("s2_flags",  32'({finished, passed, timed_out}), 32'b110);
        check("s2_cnt",    cycle_cnt,      32'd10);
        for (int i = 0; i < 20; i++) begin
            done_req = (i == 5);
            step();
        end
        done_req = 1'b0; done_pass = 1'b0;
        check("s2_hold_cnt",  cycle_cnt,   32'd10);
        check("s2_hold_pass", 32'(passed), 32'd1);

        // restart from DONE; restart inside HOLD is ignored
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("s5_state",   32'(state),   32'd0);
        check("s5_dut_rst", 32'(dut_rst), 32'd1);
        check("s5_cnt",     cycle_cnt,    32'd0);
        check("s5_flags",   32'({finished, passed, timed_out}), 32'd0);
        for (int e = 1; e <= 6; e++) begin
            restart = (e == 2);
            step();
            check("s5_re_dut_rst", 32'(dut_rst), 32'(e < 4));
            check("s5_re_run",     32'(run),     32'(e >= 6));
        end
        restart = 1'b0;

        // timeout
        steps(49);
        check("s3_pre_state", 32'(state), 32'd2);
        check("s3_pre_cnt",   cycle_cnt,  32'd49);
        step();
        check("s3_state", 32'(state), 32'd3);
        check("s3_flags", 32'({finished, passed, timed_out}), 32'b101);
        check("s3_cnt",   cycle_cnt,  32'd50);

        restart = 1'b1;
        step();
        restart = 1'b0;
        steps(6);
        check("s4_run", 32'(run), 32'd1);

        // done_req on the timeout edge wins
        steps(49);
        done_req = 1'b1; done_pass = 1'b0;
        step();
        done_req = 1'b0;
        check("s4_state", 32'(state), 32'd3);
        check("s4_flags", 32'({finished, passed, timed_out}), 32'b100);
        check("s4_cnt",   cycle_cnt,  32'd50);

        // restart beats done_req in RUN
        restart = 1'b1;
        step();
        restart = 1'b0;
        steps(9);
        restart = 1'b1; done_req = 1'b1; done_pass = 1'b1;
        step();
        restart = 1'b0; done_req = 1'b0; done_pass = 1'b0;
        check("s5b_state",   32'(state),   32'd0);
        check("s5b_dut_rst", 32'(dut_rst), 32'd1);
        check("s5b_cnt",     cycle_cnt,    32'd0);
        check("s5b_flags",   32'({finished, passed, timed_out}), 32'd0);

        // restart from SETTLE
        steps(5);
        check("settle_state", 32'(state), 32'd1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("settle_rs_state", 32'(state),   32'd0);
        check("settle_rs_rst",   32'(dut_rst), 32'd1);
        steps(6);
        steps(7);
        check("s6_cnt", cycle_cnt, 32'd7);

        // async rst between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s6_async_dut_rst", 32'(dut_rst), 32'd1);
        check("s6_async_cnt",     cycle_cnt,    32'd0);
        check("s6_async_state",   32'(state),   32'd0);
        check("s6_async_run",     32'(run),     32'd0);
        m_reset();
        step();
        rst = 1'b0;
        steps(6);
        check("s6_rerun", 32'(run), 32'd1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            restart   = ($urandom_range(0, 39) == 0);
            done_req  = ($urandom_range(0, 29) == 0);
            done_pass = ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b0; restart = 1'b0; done_req = 1'b0; done_pass = 1'b0;
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tb_runctl.md
Name: tb_runctl

Overview:
- Simulation run controller that sequences the run of a DUT clocked by the bench clock generator.
- Drives a synchronous DUT reset for a fixed number of cycles, then a settle window, then a counted run phase.
- The run phase ends on a test-completion request or a cycle-count timeout; the outcome is latched as sticky status flags.
- Sits in every bench top between the clock generator and the DUT, and gives benches one common pass/fail/timeout point.

Parameters:
- RST_CYCLES, 4: clock edges dut_rst stays asserted after rst deasserts; legal range >= 1.
- SETTLE_CYCLES, 2: clock edges between dut_rst release and run assertion; 0 means go directly from HOLD to RUN.
- TIMEOUT, 100000: maximum number of RUN-state edges before a timeout is declared; legal range >= 1.
- CNT_W, 32: width of cycle_cnt; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  bench clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high bench reset.
- restart  input  1  synchronous request to re-run the sequence from HOLD.
- done_req  input  1  test signals completion; sampled only in RUN.
- done_pass  input  1  test verdict; sampled on the edge that accepts done_req.
- dut_rst  output  1  registered, active-high reset to the DUT.
- run  output  1  high only in RUN.
- state  output  2  HOLD=0, SETTLE=1, RUN=2, DONE=3.
- cycle_cnt  output  CNT_W  number of RUN-state edges since the last HOLD.
- finished  output  1  sticky; high in DONE.
- passed  output  1  sticky; verdict.
- timed_out  output  1  sticky; run ended by timeout.

Behaviour:
- Async reset (rst=1), applied immediately without waiting for an edge:
  - state=HOLD, dut_rst=1, run=0.
  - cycle_cnt=0, hold/settle counter=0.
  - finished=passed=timed_out=0.
- rst has priority over every input. Asserting rst mid-run aborts the run at once; no status is retained.
- All outputs are registered. No combinational path from any input to any output.
- HOLD:
  - dut_rst=1.
  - The internal counter increments each edge.
  - On the RST_CYCLES-th edge after rst deasserts:
    - if SETTLE_CYCLES>0: go to SETTLE, dut_rst=0, counter cleared.
    - else: go to RUN, dut_rst=0, run=1.
  - restart and done_req are ignored in HOLD.
- SETTLE:
  - dut_rst=0, run=0.
  - After SETTLE_CYCLES edges: state=RUN, run=1.
- RUN:
  - cycle_cnt increments on every edge where state==RUN, including the exit edge.
  - Priority order on a given edge: restart > done_req > timeout.
  - restart: go to HOLD, dut_rst=1, run=0; clear cycle_cnt, counter and all flags.
  - done_req=1: go to DONE; finished=1, passed=done_pass, timed_out=0.
  - Else, if cycle_cnt==TIMEOUT-1 before the edge: go to DONE; finished=1, timed_out=1, passed=0. cycle_cnt reads TIMEOUT afterwards.
  - done_req on the same edge as the timeout: done wins, timed_out=0.
- DONE:
  - All flags and cycle_cnt hold. run=0, dut_rst=0.
  - done_req is ignored.
  - restart: behaves as in RUN (go to HOLD, clear everything).
- restart in SETTLE: go to HOLD and clear as above.
- cycle_cnt never wraps; TIMEOUT bounds it.
- No X may leave any output once rst has been asserted at least once. Before the first rst, outputs may be X.

Test Plan:
1. Defaults, rst high 3 edges then low:
   - dut_rst falls on the 4th edge after rst release.
   - run rises 2 edges later.
   - state sequence 0,1,2.
2. done_req=1, done_pass=1 on the 10th RUN edge:
   - state=3, finished=1, passed=1, timed_out=0, cycle_cnt=10.
   - cycle_cnt still 10 twenty edges later.
3. TIMEOUT=50, done_req held 0:
   - DONE after 50 RUN edges; timed_out=1, passed=0, cycle_cnt=50.
4. TIMEOUT=50, done_req=1 and done_pass=0 on exactly the 50th RUN edge:
   - timed_out=0, finished=1, passed=0, cycle_cnt=50.
5. restart pulsed in DONE, and separately on the same edge as done_req in RUN:
   - state=HOLD, flags=0, cycle_cnt=0, dut_rst=1.
   - Full sequence repeats with identical timing to scenario 1.
6. rst asserted between edges mid-RUN (cycle_cnt=7), and a separate SETTLE_CYCLES=0 build:
   - Mid-RUN rst: dut_rst=1 and cycle_cnt=0 immediately, before the next edge.
   - SETTLE_CYCLES=0: run rises on the same edge dut_rst falls.
